decode_sequencer: RTL

DECODE_SEQUENCER -- requirements
Module: decode_sequencer

---
 rtl/decode_sequencer.sv | 193 +++++++++++++++++++
 1 files changed

// File: rtl/decode_sequencer.sv
// Top-level sequencer for the image decode flow: UART receive, IDCT (M2), colourspace (M1), display.
// Owns the SRAM/multiplier arbitration and a per-stage watchdog that aborts hung stages.
module decode_sequencer #(
   parameter int RX_TIMEOUT  = 50000000,
   parameter int STAGE_LIMIT = 16777215
) (
   input  logic       CLOCK_50_I,
   input  logic       Resetn,
   input  logic       go,
   input  logic       skip_m2,
   input  logic       uart_wr,
   input  logic       uart_addr_nz,
   input  logic       M2_finish,
   input  logic       M1_finish,
   output logic       UART_rx_initialize,
   output logic       UART_rx_enable,
   output logic       M2_start,
   output logic       M1_start,
   output logic       VGA_enable,
   output logic [1:0] owner,
   output logic       stage_err,
   output logic [2:0] state
);

   localparam int WD_W = $clog2(STAGE_LIMIT + 1);
   localparam logic [25:0]     RX_LAST = 26'(RX_TIMEOUT - 1);
   localparam logic [WD_W-1:0] WD_LAST = WD_W'(STAGE_LIMIT - 1);

   localparam logic [1:0] OWN_VGA  = 2'b00;
   localparam logic [1:0] OWN_UART = 2'b01;
   localparam logic [1:0] OWN_M2   = 2'b10;
   localparam logic [1:0] OWN_M1   = 2'b11;

   typedef enum logic [2:0] {
      S_IDLE    = 3'd0,
      S_RX_EN   = 3'd1,
      S_RX_WAIT = 3'd2,
      S_M2      = 3'd3,
      S_M1      = 3'd4,
      S_DONE    = 3'd5
   } state_t;

   state_t            state_q, state_d;
   logic [25:0]       timer_q, timer_d;
   logic [WD_W-1:0]   wd_q, wd_d;
   logic              skip_q, skip_d;
   logic              err_q, err_d;
   logic              vga_q, vga_d;
   logic [1:0]        owner_q, owner_d;
   logic              init_q, init_d;
   logic              en_q, en_d;
   logic              m2s_q, m2s_d;
   logic              m1s_q, m1s_d;

   always_ff @(posedge CLOCK_50_I or negedge Resetn) begin
      if (!Resetn) begin
         state_q <= S_IDLE;
         timer_q <= '0;
         wd_q    <= '0;
         skip_q  <= 1'b0;
         err_q   <= 1'b0;
         vga_q   <= 1'b1;
         owner_q <= OWN_VGA;
         init_q  <= 1'b0;
         en_q    <= 1'b0;
         m2s_q   <= 1'b0;
         m1s_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         timer_q <= timer_d;
         wd_q    <= wd_d;
         skip_q  <= skip_d;
         err_q   <= err_d;
         vga_q   <= vga_d;
         owner_q <= owner_d;
         init_q  <= init_d;
         en_q    <= en_d;
         m2s_q   <= m2s_d;
         m1s_q   <= m1s_d;
      end
   end

   // Every output is computed one cycle ahead so that it is a flop; pulses default low, levels hold.
   always_comb begin
      state_d = state_q;
      timer_d = timer_q;
      wd_d    = wd_q;
      skip_d  = skip_q;
      err_d   = err_q;
      vga_d   = vga_q;
      owner_d = owner_q;
      init_d  = 1'b0;
      en_d    = 1'b0;
      m2s_d   = m2s_q;
      m1s_d   = m1s_q;

      case (state_q)
         S_IDLE: begin
            if (go) begin
               state_d = S_RX_EN;
               init_d  = 1'b1;
               en_d    = 1'b1;
               vga_d   = 1'b0;
               skip_d  = skip_m2;
               err_d   = 1'b0;
               owner_d = OWN_UART;
            end
         end
         S_RX_EN: begin
            state_d = S_RX_WAIT;
            timer_d = '0;
         end
         S_RX_WAIT: begin
            // A write landing on the timeout cycle keeps reception alive.
            if (uart_wr) begin
               timer_d = '0;
            end else if (timer_q == RX_LAST) begin
               timer_d = '0;
               if (uart_addr_nz) begin
                  init_d = 1'b1;
                  wd_d   = '0;
                  if (skip_q) begin
                     state_d = S_M1;
                     owner_d = OWN_M1;
                  end else begin
                     state_d = S_M2;
                     owner_d = OWN_M2;
                  end
               end
            end else begin
               timer_d = timer_q + 26'd1;
            end
         end
         S_M2: begin
            if (m2s_q && M2_finish) begin
               m2s_d   = 1'b0;
               state_d = S_M1;
               owner_d = OWN_M1;
               wd_d    = '0;
            end else if (wd_q == WD_LAST) begin
               m2s_d   = 1'b0;
               err_d   = 1'b1;
               vga_d   = 1'b1;
               owner_d = OWN_VGA;
               state_d = S_IDLE;
               wd_d    = '0;
            end else begin
               m2s_d = 1'b1;
               wd_d  = wd_q + WD_W'(1);
            end
         end
         S_M1: begin
            if (m1s_q && M1_finish) begin
               m1s_d   = 1'b0;
               vga_d   = 1'b1;
               owner_d = OWN_VGA;
               state_d = S_DONE;
               wd_d    = '0;
            end else if (wd_q == WD_LAST) begin
               m1s_d   = 1'b0;
               err_d   = 1'b1;
               vga_d   = 1'b1;
               owner_d = OWN_VGA;
               state_d = S_IDLE;
               wd_d    = '0;
            end else begin
               m1s_d = 1'b1;
               wd_d  = wd_q + WD_W'(1);
            end
         end
         S_DONE: begin
            state_d = S_IDLE;
         end
         default: begin
            state_d = S_IDLE;
            vga_d   = 1'b1;
            owner_d = OWN_VGA;
            m2s_d   = 1'b0;
            m1s_d   = 1'b0;
         end
      endcase
   end

   assign UART_rx_initialize = init_q;
   assign UART_rx_enable     = en_q;
   assign M2_start           = m2s_q;
   assign M1_start           = m1s_q;
   assign VGA_enable         = vga_q;
   assign owner              = owner_q;
   assign stage_err          = err_q;
   assign state              = state_q;

endmodule
